uart_word_tx: RTL and testbench

UART_WORD_TX -- requirements
Module: uart_word_tx

---
 rtl/uart_word_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_word_tx.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// -----------------------------------------------------------------------------
// uart_word_tx
//
// Serialises one 16-bit result word as two back-to-back UART bytes on a single
// transmit line: low byte first, then high byte, each LSB first with one start
// bit (0) and one stop bit (1). The second start bit follows the first stop
// bit with no idle gap, so a word occupies exactly 20 bit times (22 with
// parity).
//
// Optional feature (compile-time macro UART_TX_PARITY_EN):
//   When defined, an even-parity bit (XOR of the 8 data bits) is inserted
//   between the data bits and the stop bit of each byte. When undefined, the
//   PARITY state and its logic do not exist and framing is plain 8N1.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per UART bit (>= 2), 434 = 50 MHz / 115200 baud
//   WORD_W       - word width; the framing below assumes 16 (two bytes)
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   rst        in   asynchronous active-low reset
//   data_in    in   word to transmit
//   data_valid in   data_in is valid this cycle
//   data_ready out  a word can be accepted this cycle (only in IDLE)
//   tx         out  UART serial line, idles high, always driven from a flop
//   busy       out  high from acceptance until the last stop bit ends
//   done       out  one-cycle pulse in the last cycle of byte 1's stop bit
// -----------------------------------------------------------------------------
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int WORD_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    // Baud counter is just wide enough to count 0 .. CLKS_PER_BIT-1.
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] BAUD_ZERO   = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] BAUD_ONE    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] BAUD_LAST   = CNT_W'(CLKS_PER_BIT - 32'd1);
    // One cycle before the end of a bit: lets done be registered yet still
    // appear during the final cycle of the stop bit.
    localparam logic [CNT_W-1:0] BAUD_PENULT = CNT_W'(CLKS_PER_BIT - 32'd2);

    localparam logic [2:0] BIT_FIRST = 3'd0;
    localparam logic [2:0] BIT_LAST  = 3'd7;
    localparam logic [2:0] BIT_STEP  = 3'd1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity over one data byte: the bit that makes the total count of
    // ones (data + parity) even.
    function automatic logic even_parity(input logic [7:0] byte_val);
        return ^byte_val;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t            state_r;
    logic [WORD_W-1:0] data_r;      // word latched at acceptance
    logic              byte_sel_r;  // 0: sending data_r[7:0], 1: data_r[15:8]
    logic [2:0]        bit_idx_r;   // data bit currently on the line
    logic [CNT_W-1:0]  baud_cnt_r;  // cycles elapsed within the current bit

    logic [7:0]        cur_byte_s;
    logic [2:0]        next_idx_s;
    logic              bit_end_s;
    logic              accept_s;
    logic              done_set_s;

    // Byte currently being serialised.
    always_comb begin
        if (byte_sel_r) begin
            cur_byte_s = data_r[15:8];
        end else begin
            cur_byte_s = data_r[7:0];
        end
    end

    // Bit-timing and handshake decodes. data_ready is only ever high in IDLE,
    // so accept_s cannot fire in any other state.
    always_comb begin
        next_idx_s = bit_idx_r + BIT_STEP;
        bit_end_s  = (baud_cnt_r == BAUD_LAST);
        accept_s   = data_valid & data_ready;
        if ((state_r == STOP) && byte_sel_r && (baud_cnt_r == BAUD_PENULT)) begin
            done_set_s = 1'b1;
        end else begin
            done_set_s = 1'b0;
        end
    end

    // Transmit FSM with registered line, handshake and status outputs.
    // Every bit transition loads the value of the next bit into tx on the same
    // edge that restarts the baud counter, so each bit lasts CLKS_PER_BIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            data_r     <= {WORD_W{1'b0}};
            byte_sel_r <= 1'b0;
            bit_idx_r  <= BIT_FIRST;
            baud_cnt_r <= BAUD_ZERO;
            tx         <= 1'b1;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= done_set_s;

            case (state_r)
                IDLE: begin
                    baud_cnt_r <= BAUD_ZERO;
                    bit_idx_r  <= BIT_FIRST;
                    byte_sel_r <= 1'b0;
                    if (accept_s) begin
                        data_r     <= data_in;
                        state_r    <= START;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        data_ready <= 1'b0;
                    end else begin
                        tx         <= 1'b1;
                        busy       <= 1'b0;
                        data_ready <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        bit_idx_r  <= BIT_FIRST;
                        tx         <= cur_byte_s[BIT_FIRST];
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end

                DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        if (bit_idx_r == BIT_LAST) begin
                            bit_idx_r <= BIT_FIRST;
`ifdef UART_TX_PARITY_EN
                            tx        <= even_parity(cur_byte_s);
                            state_r   <= PARITY;
`else
                            tx        <= 1'b1;
                            state_r   <= STOP;
`endif
                        end else begin
                            bit_idx_r <= next_idx_s;
                            tx        <= cur_byte_s[next_idx_s];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        tx         <= 1'b1;
                        state_r    <= STOP;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
`endif

                STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        if (!byte_sel_r) begin
                            // High byte starts straight after the low byte's
                            // stop bit, no idle cycle in between.
                            byte_sel_r <= 1'b1;
                            tx         <= 1'b0;
                            state_r    <= START;
                        end else begin
                            byte_sel_r <= 1'b0;
                            tx         <= 1'b1;
                            busy       <= 1'b0;
                            data_ready <= 1'b1;
                            state_r    <= IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end

                default: begin
                    state_r    <= IDLE;
                    byte_sel_r <= 1'b0;
                    bit_idx_r  <= BIT_FIRST;
                    baud_cnt_r <= BAUD_ZERO;
                    tx         <= 1'b1;
                    busy       <= 1'b0;
                    data_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_word_tx
//
// Self-checking bench for uart_word_tx with CLKS_PER_BIT = 4. Expected line
// levels come from a frame model that derives the bit at any cycle offset
// from the word value by plain arithmetic (bit number = cycle / CLKS_PER_BIT,
// position inside the byte frame = start / data / parity / stop).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// that same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_uart_word_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int BYTE_BITS = 11;
`else
    localparam int BYTE_BITS = 10;
`endif
    localparam int FRAME     = 2 * BYTE_BITS * CPB;
    localparam int WAIT_MAX  = 200;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        tx;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fails;

    uart_word_tx #(.CLKS_PER_BIT(CPB), .WORD_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: line level at cycle c (0 = first start-bit cycle).
    function automatic logic exp_tx(input logic [15:0] w, input int c);
        int         bit_no;
        int         pos;
        logic [7:0] b;
        bit_no = c / CPB;
        pos    = bit_no % BYTE_BITS;
        b      = ((bit_no / BYTE_BITS) == 0) ? w[7:0] : w[15:8];
        if (pos == 0)                   return 1'b0;
        else if (pos <= 8)              return b[pos-1];
        else if (pos == BYTE_BITS - 1)  return 1'b1;
        else                            return ^b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and wait (bounded) until the next edge will accept it;
    // returns with the bench positioned in cycle 0 of the new frame.
    task automatic offer_word(input logic [15:0] w);
        int waited;
        data_in    = w;
        data_valid = 1'b1;
        waited     = 0;
        while (data_ready !== 1'b1 && waited < WAIT_MAX) begin
            tick();
            waited++;
        end
        n_checks++;
        if (data_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL offer_wait: data_ready=%b required 1 within %0d cycles", data_ready, WAIT_MAX);
        end
        tick();
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        data_valid = 1'b0;
        data_in    = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (tx !== 1'b1 || data_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_state: tx=%b ready=%b busy=%b done=%b required 1 0 0 0", tx, data_ready, busy, done);
            end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (data_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_release_pre: data_ready=%b required 0", data_ready);
        end
        tick();
        n_checks++;
        if (data_ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_release_ready: ready=%b tx=%b busy=%b required 1 1 0", data_ready, tx, busy);
        end
    endtask

    task automatic test_single_word();
        logic [15:0] w;
        int          done_cnt;
        w        = 16'hA55A;
        done_cnt = 0;
        offer_word(w);
        data_valid = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            n_checks++;
            if (tx !== exp_tx(w, c)) begin
                n_fails++;
                $display("FAIL single_tx: word=%h cycle=%0d tx=%b required %b", w, c + 1, tx, exp_tx(w, c));
            end
            n_checks++;
            if (done !== (c == FRAME - 1)) begin
                n_fails++;
                $display("FAIL single_done: cycle=%0d done=%b required %b", c + 1, done, (c == FRAME - 1));
            end
            if (done === 1'b1) done_cnt++;
            n_checks++;
            if (busy !== 1'b1 || data_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL single_status: cycle=%0d busy=%b ready=%b required 1 0", c + 1, busy, data_ready);
            end
            tick();
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fails++;
            $display("FAIL single_done_count: pulses=%0d required 1", done_cnt);
        end
        n_checks++;
        if (busy !== 1'b0 || data_ready !== 1'b1 || tx !== 1'b1 || done !== 1'b0) begin
            n_fails++;
            $display("FAIL single_end: busy=%b ready=%b tx=%b done=%b required 0 1 1 0", busy, data_ready, tx, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [2];
        words[0] = 16'h1234;
        words[1] = 16'hFFFF;
        offer_word(words[0]);
        data_in = words[1];             // keep offering, now the second word
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < FRAME; c++) begin
                n_checks++;
                if (tx !== exp_tx(words[k], c)) begin
                    n_fails++;
                    $display("FAIL b2b_tx: word=%h cycle=%0d tx=%b required %b", words[k], c + 1, tx, exp_tx(words[k], c));
                end
                n_checks++;
                if (data_ready !== 1'b0 || done !== (c == FRAME - 1)) begin
                    n_fails++;
                    $display("FAIL b2b_hs: word=%h cycle=%0d ready=%b done=%b required 0 %b", words[k], c + 1, data_ready, done, (c == FRAME - 1));
                end
                if (k == 1) data_valid = 1'b0;
                tick();
            end
            // The single gap cycle: line high, block ready, nothing accepted yet.
            n_checks++;
            if (tx !== 1'b1 || data_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                n_fails++;
                $display("FAIL b2b_gap: word=%h tx=%b ready=%b busy=%b done=%b required 1 1 0 0", words[k], tx, data_ready, busy, done);
            end
            if (k == 0) tick();         // data_valid still high: accepted on this edge
        end
    endtask

    task automatic test_boundary();
        logic [15:0] words [2];
        words[0] = 16'h0000;
        words[1] = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            offer_word(words[k]);
            data_valid = 1'b0;
            for (int c = 0; c < FRAME; c++) begin
                n_checks++;
                if (tx !== exp_tx(words[k], c) || busy !== 1'b1) begin
                    n_fails++;
                    $display("FAIL boundary_tx: word=%h cycle=%0d tx=%b busy=%b required %b 1", words[k], c + 1, tx, busy, exp_tx(words[k], c));
                end
                tick();
            end
            n_checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1) begin
                n_fails++;
                $display("FAIL boundary_end: word=%h tx=%b busy=%b ready=%b required 1 0 1", words[k], tx, busy, data_ready);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] w;
        offer_word(16'h00FF);
        data_valid = 1'b0;
        for (int c = 0; c < 29; c++) tick();
        rst = 1'b0;                     // cycle 30 of the frame
        #1;
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b0 || done !== 1'b0) begin
            n_fails++;
            $display("FAIL midreset_async: tx=%b busy=%b ready=%b done=%b required 1 0 0 0", tx, busy, data_ready, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (tx !== 1'b1 || done !== 1'b0) begin
                n_fails++;
                $display("FAIL midreset_hold: tx=%b done=%b required 1 0", tx, done);
            end
        end
        rst = 1'b1;
        tick();
        w = 16'h0F0F;
        offer_word(w);
        data_valid = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            n_checks++;
            if (tx !== exp_tx(w, c) || done !== (c == FRAME - 1)) begin
                n_fails++;
                $display("FAIL midreset_resend: cycle=%0d tx=%b done=%b required %b %b", c + 1, tx, done, exp_tx(w, c), (c == FRAME - 1));
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int k = 0; k < 6; k++) begin
            data_valid = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
            w = 16'($urandom);
            offer_word(w);
            for (int c = 0; c < FRAME; c++) begin
                n_checks++;
                if (tx !== exp_tx(w, c) || done !== (c == FRAME - 1) || data_ready !== 1'b0) begin
                    n_fails++;
                    $display("FAIL random_tx: word=%h cycle=%0d tx=%b done=%b ready=%b required %b %b 0", w, c + 1, tx, done, data_ready, exp_tx(w, c), (c == FRAME - 1));
                end
                // Noise on the input side must not disturb the frame in flight.
                if (c < FRAME - 1) begin
                    data_valid = 1'($urandom);
                    data_in    = 16'($urandom);
                end else begin
                    data_valid = 1'b0;
                end
                tick();
            end
            n_checks++;
            if (busy !== 1'b0 || data_ready !== 1'b1) begin
                n_fails++;
                $display("FAIL random_end: word=%h busy=%b ready=%b required 0 1", w, busy, data_ready);
            end
        end
        data_valid = 1'b0;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [15:0] w;
        w = 16'h0301;
        offer_word(w);
        data_valid = 1'b0;
        for (int c = 0; c < 88; c++) begin
            n_checks++;
            if (tx !== exp_tx(w, c) || done !== (c == 87)) begin
                n_fails++;
                $display("FAIL parity_tx: cycle=%0d tx=%b done=%b required %b %b", c + 1, tx, done, exp_tx(w, c), (c == 87));
            end
            // Parity bit of byte 0 (0x01) is 1, of byte 1 (0x03) is 0.
            if (c == 9 * CPB) begin
                n_checks++;
                if (tx !== 1'b1) begin
                    n_fails++;
                    $display("FAIL parity_bit0: tx=%b required 1", tx);
                end
            end
            if (c == 20 * CPB) begin
                n_checks++;
                if (tx !== 1'b0) begin
                    n_fails++;
                    $display("FAIL parity_bit1: tx=%b required 0", tx);
                end
            end
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || data_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL parity_end: busy=%b ready=%b required 0 1", busy, data_ready);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_boundary();
        test_reset_midframe();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
